cordic_vectoring_atan2: RTL



---
 rtl/cordic_atan_radian_table_pkg.sv | 85 ++++++++
 rtl/cordic_vectoring_stage.sv | 39 +++
 rtl/cordic_vectoring_atan2.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/cordic_atan_radian_table_pkg.sv
// Shared CORDIC radian tables (n4q60 atan and gain) plus the vectoring FSM state type.
// Table entries are derived with constant functions so every width picks identical values.
package cordic_atan_radian_table_pkg;

  typedef logic [31:0][63:0] table32_t;

  localparam logic [63:0] PI_2_N4Q60 = 64'h1921FB54442D1846;
  localparam logic [63:0] PI_2_Q50   = 64'h0006487ED5110B46;
  localparam logic [63:0] PI_4_Q50   = 64'h0003243F6A8885A3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PREROT = 3'd1,
    ST_ITER   = 3'd2,
    ST_SCALE  = 3'd3,
    ST_DONE   = 3'd4
  } vec_state_e;

  // atan(2^-i) from its Taylor series in q120, rounded to q60; i=0 is exactly pi/4
  function automatic logic [63:0] atan_pow2_n4q60(input int unsigned i);
    logic [127:0] acc;
    logic [127:0] term;
    int unsigned  e;
    acc = 128'd0;
    for (int unsigned k = 0; k < 64; k++) begin
      e = i * (2 * k + 1);
      if (e <= 120) begin
        term = (128'd1 << (120 - e)) / 128'(2 * k + 1);
        if ((k % 2) == 0) begin
          acc = acc + term;
        end else begin
          acc = acc - term;
        end
      end else begin
        acc = acc;
      end
    end
    acc = acc + (128'd1 << 59);
    if (i == 0) begin
      return PI_2_N4Q60 >> 1;
    end else begin
      return 64'(acc >> 60);
    end
  endfunction

  function automatic logic [63:0] gain_n4q60(input int unsigned n);
    logic [127:0] p2;
    logic [127:0] s;
    logic [127:0] trial;
    p2 = 128'd1 << 120;
    for (int unsigned i = 0; i <= n; i++) begin
      p2 = p2 + (p2 >> (2 * i));
    end
    s = 128'd0;
    for (int j = 63; j >= 0; j--) begin
      trial = s | (128'd1 << j);
      if ((trial * trial) <= p2) begin
        s = trial;
      end else begin
        s = s;
      end
    end
    return 64'((128'd1 << 120) / s);
  endfunction

  function automatic table32_t build_atan_table();
    table32_t t;
    for (int i = 0; i < 32; i++) begin
      t[i] = atan_pow2_n4q60(i);
    end
    return t;
  endfunction

  function automatic table32_t build_gain_table();
    table32_t t;
    for (int i = 0; i < 32; i++) begin
      t[i] = gain_n4q60(i);
    end
    return t;
  endfunction

  localparam table32_t atan_radian_table_32stage_n4q60 = build_atan_table();
  localparam table32_t gain_table_32stage_n4q60        = build_gain_table();

endpackage

// File: rtl/cordic_vectoring_stage.sv
// One combinational vectoring micro-rotation: drives y toward zero, accumulating angle in z.
module cordic_vectoring_stage
  import cordic_atan_radian_table_pkg::*;
#(
  parameter int W = 34
) (
  input  logic signed [W-1:0] i_x,
  input  logic signed [W-1:0] i_y,
  input  logic signed [63:0]  i_z,
  input  logic [4:0]          i_shift,
  input  logic signed [63:0]  i_atan,
  output logic signed [W-1:0] o_x,
  output logic signed [W-1:0] o_y,
  output logic signed [63:0]  o_z
);

  logic signed [W-1:0] w_xs;
  logic signed [W-1:0] w_ys;

  assign w_xs = i_x >>> i_shift;
  assign w_ys = i_y >>> i_shift;

  // rotation direction follows the sign of y
  always_comb begin
    o_x = i_x;
    o_y = i_y;
    o_z = i_z;
    if (!i_y[W-1]) begin
      o_x = i_x + w_ys;
      o_y = i_y - w_xs;
      o_z = i_z + i_atan;
    end else begin
      o_x = i_x - w_ys;
      o_y = i_y + w_xs;
      o_z = i_z - i_atan;
    end
  end

endmodule

// File: rtl/cordic_vectoring_atan2.sv
// Iterative vectoring CORDIC: (x, y) -> atan2(y, x) in n4q60 radians and gain-corrected magnitude.
module cordic_vectoring_atan2
  import cordic_atan_radian_table_pkg::*;
#(
  parameter int WIDTH_P        = 32,
  parameter int NR_OF_STAGES_P = 31
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ing_valid,
  output logic               ing_ready,
  input  logic [WIDTH_P-1:0] ing_x,
  input  logic [WIDTH_P-1:0] ing_y,
  output logic               egr_valid,
  input  logic               egr_ready,
  output logic [63:0]        egr_angle,
  output logic [WIDTH_P:0]   egr_magnitude
);

  localparam int          XW       = WIDTH_P + 2;
  localparam int          PW       = WIDTH_P + 66;
  localparam logic [4:0]  LAST_IDX = 5'(NR_OF_STAGES_P - 1);
  localparam logic [63:0] GAIN_N   = gain_table_32stage_n4q60[NR_OF_STAGES_P - 1];
  localparam logic [63:0] PI_2_Q60 = PI_2_Q50 << 10;

  vec_state_e           r_state;
  vec_state_e           w_state_nxt;
  logic                 r_ing_ready;
  logic                 w_ing_ready_nxt;
  logic                 r_egr_valid;
  logic                 w_egr_valid_nxt;
  logic signed [XW-1:0] r_x;
  logic signed [XW-1:0] r_y;
  logic signed [63:0]   r_z;
  logic [4:0]           r_cnt;
  logic                 r_zero;
  logic [63:0]          r_egr_angle;
  logic [WIDTH_P:0]     r_egr_magnitude;
  logic signed [XW-1:0] w_stage_x;
  logic signed [XW-1:0] w_stage_y;
  logic signed [63:0]   w_stage_z;
  logic                 w_ing_fire;
  logic                 w_egr_fire;
  logic signed [PW-1:0] w_x_ext;
  logic signed [PW-1:0] w_gain_ext;
  logic signed [PW-1:0] w_product;
  logic                 w_unused_product;

  assign w_ing_fire = ing_valid & r_ing_ready;
  assign w_egr_fire = r_egr_valid & egr_ready;

  // next state plus next values of the registered handshake outputs
  always_comb begin
    w_state_nxt     = r_state;
    w_ing_ready_nxt = 1'b0;
    w_egr_valid_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_ing_fire) begin
          w_state_nxt = ST_PREROT;
        end else begin
          w_state_nxt     = ST_IDLE;
          w_ing_ready_nxt = 1'b1;
        end
      end
      ST_PREROT: begin
        w_state_nxt = ST_ITER;
      end
      ST_ITER: begin
        if (r_cnt == LAST_IDX) begin
          w_state_nxt = ST_SCALE;
        end else begin
          w_state_nxt = ST_ITER;
        end
      end
      ST_SCALE: begin
        w_state_nxt     = ST_DONE;
        w_egr_valid_nxt = 1'b1;
      end
      ST_DONE: begin
        if (w_egr_fire) begin
          w_state_nxt     = ST_IDLE;
          w_ing_ready_nxt = 1'b1;
        end else begin
          w_state_nxt     = ST_DONE;
          w_egr_valid_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // state and handshake registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_ing_ready <= 1'b0;
      r_egr_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ing_ready <= w_ing_ready_nxt;
      r_egr_valid <= w_egr_valid_nxt;
    end
  end

  cordic_vectoring_stage #(
    .W (XW)
  ) u_stage (
    .i_x     (r_x),
    .i_y     (r_y),
    .i_z     (r_z),
    .i_shift (r_cnt),
    .i_atan  ($signed(atan_radian_table_32stage_n4q60[r_cnt])),
    .o_x     (w_stage_x),
    .o_y     (w_stage_y),
    .o_z     (w_stage_z)
  );

  assign w_x_ext          = {{(PW - XW){r_x[XW-1]}}, r_x};
  assign w_gain_ext       = {{(PW - 64){GAIN_N[63]}}, GAIN_N};
  assign w_product        = w_x_ext * w_gain_ext;
  assign w_unused_product = ^{w_product[59:0], w_product[PW-1:WIDTH_P+61]};

  // datapath: capture, quadrant fold into [-pi/2, pi/2], micro-rotations, gain correction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x             <= '0;
      r_y             <= '0;
      r_z             <= 64'sd0;
      r_cnt           <= 5'd0;
      r_zero          <= 1'b0;
      r_egr_angle     <= 64'd0;
      r_egr_magnitude <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_ing_fire) begin
            r_x    <= {{2{ing_x[WIDTH_P-1]}}, ing_x};
            r_y    <= {{2{ing_y[WIDTH_P-1]}}, ing_y};
            r_z    <= 64'sd0;
            r_zero <= (ing_x == {WIDTH_P{1'b0}}) && (ing_y == {WIDTH_P{1'b0}});
          end
        end
        ST_PREROT: begin
          r_cnt <= 5'd0;
          if (r_x[XW-1] && !r_y[XW-1]) begin
            r_x <= r_y;
            r_y <= -r_x;
            r_z <= $signed(PI_2_Q60);
          end else if (r_x[XW-1]) begin
            r_x <= -r_y;
            r_y <= r_x;
            r_z <= -$signed(PI_2_Q60);
          end else begin
            r_z <= 64'sd0;
          end
        end
        ST_ITER: begin
          r_x   <= w_stage_x;
          r_y   <= w_stage_y;
          r_z   <= w_stage_z;
          r_cnt <= r_cnt + 5'd1;
        end
        ST_SCALE: begin
          if (r_zero) begin
            r_egr_angle     <= 64'd0;
            r_egr_magnitude <= '0;
          end else begin
            r_egr_angle     <= r_z;
            r_egr_magnitude <= w_product[WIDTH_P+60:60];
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign ing_ready     = r_ing_ready;
  assign egr_valid     = r_egr_valid;
  assign egr_angle     = r_egr_angle;
  assign egr_magnitude = r_egr_magnitude;

endmodule
